// File: rtl/instr_queue_reg_if.sv
// Instruction queue handshake bundle: source side drives master,
// queue drives slave. Parity lines exist only with INSQ_PARITY_EN.
interface instr_queue_reg_if #(
  parameter int INS_W = 16,
  parameter int OP_W  = 4,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               loadIR;
  logic [INS_W-1:0]   insin;
  logic               ins_ready;
  logic               next;
  logic               flush;
  logic               ir_valid;
  logic [OP_W-1:0]    opcode;
  logic [INS_W-OP_W-1:0] address;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               ovf;
  logic               udf;
`ifdef INSQ_PARITY_EN
  logic               ins_par;
  logic               par_err;
`endif

  modport master (
`ifdef INSQ_PARITY_EN
    output ins_par,
    input  par_err,
`endif
    output loadIR, insin, next, flush,
    input  ins_ready, ir_valid, opcode, address,
    input  count, full, empty, ovf, udf
  );

  modport slave (
`ifdef INSQ_PARITY_EN
    input  ins_par,
    output par_err,
`endif
    input  loadIR, insin, next, flush,
    output ins_ready, ir_valid, opcode, address,
    output count, full, empty, ovf, udf
  );
endinterface

// File: rtl/instr_queue_reg.sv
// DEPTH-entry instruction FIFO; head is the current instruction.
// Optional input parity check enabled by INSQ_PARITY_EN.
module instr_queue_reg #(
  parameter int INS_W = 16,
  parameter int OP_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_queue_reg_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AD_W  = INS_W - OP_W;

  logic [INS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             udf_q;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;
  logic [INS_W-1:0] head;

  assign full_w  = (cnt == CNT_W'(DEPTH));
  assign empty_w = (cnt == '0);
  assign pop     = bus.next && !empty_w;

`ifdef INSQ_PARITY_EN
  logic par_ok;
  logic perr_q;
  assign par_ok = ~(^{bus.insin, bus.ins_par});
  assign push   = bus.loadIR && !full_w && par_ok;

  // sticky parity error on a ready push with bad parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perr_q <= 1'b0;
    else if (bus.flush)
      perr_q <= 1'b0;
    else if (bus.loadIR && !full_w && !par_ok)
      perr_q <= 1'b1;
  end

  assign bus.par_err = perr_q;
`else
  assign push = bus.loadIR && !full_w;
`endif

  // storage write; flush leaves stale data, pointers hide it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (!bus.flush && push) begin
      mem[wr_ptr] <= bus.insin;
    end
  end

  // pointers, occupancy and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        cnt <= cnt + CNT_W'(1);
      else if (pop && !push)
        cnt <= cnt - CNT_W'(1);
      if (bus.loadIR && full_w)
        ovf_q <= 1'b1;
      if (bus.next && empty_w)
        udf_q <= 1'b1;
    end
  end

  assign head = mem[rd_ptr];

  assign bus.ins_ready = !full_w;
  assign bus.ir_valid  = !empty_w;
  assign bus.opcode    = empty_w ? '0 : head[INS_W-1 -: OP_W];
  assign bus.address   = empty_w ? '0 : head[AD_W-1:0];
  assign bus.count     = cnt;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;
endmodule

// File: tb/tb_instr_queue_reg.sv
// Bench for instr_queue_reg: queue model checked every cycle
// plus directed literal expectations.
module tb_instr_queue_reg;
  localparam int INS_W = 16;
  localparam int OP_W  = 4;
  localparam int DEPTH = 4;
  localparam int AD_W  = INS_W - OP_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 0;
  bit   par_bad = 0;

  instr_queue_reg_if #(.INS_W(INS_W), .OP_W(OP_W), .DEPTH(DEPTH)) bus ();

  instr_queue_reg #(.INS_W(INS_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: a plain queue plus sticky flags
  logic [INS_W-1:0] mq [$];
  bit mov, mud, mpe;
  bit pu, po;
  int n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mov = 0; mud = 0; mpe = 0;
    end else if (bus.flush) begin
      mq.delete();
      mov = 0; mud = 0; mpe = 0;
    end else begin
      n  = mq.size();
      pu = bus.loadIR && (n < DEPTH);
      po = bus.next && (n > 0);
      if (bus.loadIR && n == DEPTH) mov = 1;
      if (bus.next && n == 0) mud = 1;
`ifdef INSQ_PARITY_EN
      if (pu && ((^bus.insin) ^ bus.ins_par)) begin
        pu = 0;
        mpe = 1;
      end
`endif
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(bus.insin);
    end
  end

  logic [INS_W-1:0] eh;
  int ec;

  always @(negedge clk) begin
    if (chk_on) begin
      ec = mq.size();
      eh = (ec > 0) ? mq[0] : '0;
      chk("m_valid", 32'(bus.ir_valid), 32'(ec > 0));
      chk("m_opcode", 32'(bus.opcode), 32'(eh >> AD_W));
      chk("m_address", 32'(bus.address), 32'(eh[AD_W-1:0]));
      chk("m_count", 32'(bus.count), 32'(ec));
      chk("m_full", 32'(bus.full), 32'(ec == DEPTH));
      chk("m_empty", 32'(bus.empty), 32'(ec == 0));
      chk("m_ready", 32'(bus.ins_ready), 32'(ec != DEPTH));
      chk("m_ovf", 32'(bus.ovf), 32'(mov));
      chk("m_udf", 32'(bus.udf), 32'(mud));
`ifdef INSQ_PARITY_EN
      chk("m_perr", 32'(bus.par_err), 32'(mpe));
`endif
    end
  end

  task automatic drive(input logic ld, input logic [15:0] d,
                       input logic nx, input logic fl);
    bus.loadIR = ld;
    bus.insin  = d;
    bus.next   = nx;
    bus.flush  = fl;
`ifdef INSQ_PARITY_EN
    bus.ins_par = (^d) ^ par_bad;
`endif
  endtask

  task automatic step(input logic ld, input logic [15:0] d,
                      input logic nx, input logic fl);
    drive(ld, d, nx, fl);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] seq [4] = '{16'h50AA, 16'hF00F, 16'h1234, 16'h2345};

  initial begin
    drive(0, 16'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_on = 1;
    chk("rst_valid", 32'(bus.ir_valid), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ready", 32'(bus.ins_ready), 1);

    step(1, 16'hB0F0, 0, 0);
    chk("p1_valid", 32'(bus.ir_valid), 1);
    chk("p1_op", 32'(bus.opcode), 32'hB);
    chk("p1_addr", 32'(bus.address), 32'h0F0);
    chk("p1_count", 32'(bus.count), 1);
    chk("p1_empty", 32'(bus.empty), 0);
    step(0, 16'h0, 1, 0);
    chk("p1_drain", 32'(bus.empty), 1);

    for (int i = 0; i < 4; i++) step(1, seq[i], 0, 0);
    step(1, 16'h3456, 0, 0);
    chk("ov_full", 32'(bus.full), 1);
    chk("ov_ready", 32'(bus.ins_ready), 0);
    chk("ov_flag", 32'(bus.ovf), 1);
    chk("ov_op", 32'(bus.opcode), 32'h5);
    chk("ov_count", 32'(bus.count), 4);

    for (int i = 0; i < 4; i++) begin
      chk("pop_head", 32'({bus.opcode, bus.address}), 32'(seq[i]));
      step(0, 16'h0, 1, 0);
    end
    chk("pop_empty", 32'(bus.empty), 1);
    chk("pop_op0", 32'(bus.opcode), 0);
    chk("pop_ad0", 32'(bus.address), 0);
    chk("pop_udf0", 32'(bus.udf), 0);
    step(0, 16'h0, 1, 0);
    chk("udf_flag", 32'(bus.udf), 1);

    step(1, 16'hABCD, 1, 0);
    chk("pe_count", 32'(bus.count), 1);
    chk("pe_op", 32'(bus.opcode), 32'hA);

    for (int i = 0; i < 10; i++) begin
      step(1, 16'h1000 + 16'(i), 1, 0);
      chk("wr_count", 32'(bus.count), 1);
      chk("wr_head", 32'({bus.opcode, bus.address}), 32'h1000 + i);
    end

    step(1, 16'hC001, 0, 0);
    step(1, 16'hC002, 0, 0);
    step(1, 16'hC003, 0, 0);
    chk("fp_full", 32'(bus.full), 1);
    step(1, 16'hDEAD, 1, 0);
    chk("fp_count", 32'(bus.count), 3);
    chk("fp_op", 32'(bus.opcode), 32'hC);
    chk("fp_addr", 32'(bus.address), 32'h001);
    chk("fp_ovf", 32'(bus.ovf), 1);

    step(1, 16'hBEEF, 0, 1);
    chk("fl_count", 32'(bus.count), 0);
    chk("fl_empty", 32'(bus.empty), 1);
    chk("fl_ovf", 32'(bus.ovf), 0);
    chk("fl_udf", 32'(bus.udf), 0);
    chk("fl_valid", 32'(bus.ir_valid), 0);

    step(1, 16'h7777, 0, 0);
    step(1, 16'h8888, 0, 0);
    step(1, 16'h9999, 0, 0);
    drive(0, 16'h0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.ir_valid), 0);
    chk("ar_count", 32'(bus.count), 0);
    chk("ar_op", 32'(bus.opcode), 0);
    chk("ar_addr", 32'(bus.address), 0);
    chk("ar_full", 32'(bus.full), 0);
    chk("ar_empty", 32'(bus.empty), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 16'h0, 0, 0);

`ifdef INSQ_PARITY_EN
    par_bad = 1;
    step(1, 16'h0001, 0, 0);
    chk("pb_count", 32'(bus.count), 0);
    chk("pb_err", 32'(bus.par_err), 1);
    par_bad = 0;
    step(1, 16'h0001, 0, 0);
    chk("pg_count", 32'(bus.count), 1);
    chk("pg_op", 32'(bus.opcode), 0);
    chk("pg_addr", 32'(bus.address), 32'h001);
    step(0, 16'h0, 0, 1);
    chk("pf_err", 32'(bus.par_err), 0);
`endif

    step(0, 16'h0, 0, 0);
    step(0, 16'h0, 0, 0);
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
